// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus (master_out_port / slave_in_port).
// Holds default field widths, the transfer FSM state encoding and the op encoding.
package bus_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 8;
    localparam int BURST_W_DEF = 13;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } bus_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } bus_op_e;

    // A request is only meaningful when exactly one op strobe is set.
    function automatic logic op_valid(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/bus_piso.sv
// Parallel-in serial-out shift register, LSB-first.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : capture din_i (wins over shift_i)
//   shift_i       : advance one bit towards the LSB, zero-fill at the top
//   din_i         : parallel word
//   sout_o        : current LSB (the next bit to be transmitted)
module bus_piso #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] din_i,
    output logic         sout_o
);

    logic [W-1:0] sr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      sr_q <= '0;
        else if (load_i)  sr_q <= din_i;
        else if (shift_i) sr_q <= sr_q >> 1;
    end

    assign sout_o = sr_q[0];

endmodule

// File: rtl/master_out_port.sv
// Transmit side of the serial system bus. Takes a parallel request from the
// master core, handshakes with master_valid/slave_ready, then serializes the
// address (and, for writes, the data beats) LSB-first on tx_addr/tx_data.
// Ports:
//   clk, reset                 : clock, async active-low reset
//   start, read_req, write_req : request strobe and op select
//   addr_in, data_in, burst_in : request fields (data_in re-sampled on data_next)
//   slave_ready                : slave accepts the pending request
//   master_ready               : idle, a start will be accepted
//   master_valid, read_en,
//   write_en, burst            : request presented to the slave
//   tx_addr, tx_data           : serial lines
//   data_next                  : next write beat is captured at the end of this cycle
//   tx_done                    : one-cycle end-of-transaction pulse
// Every output is a flop; the comb block computes next-cycle output values.
module master_out_port
    import bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               read_req,
    input  logic               write_req,
    input  logic [ADDR_W-1:0]  addr_in,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [BURST_W-1:0] burst_in,
    input  logic               slave_ready,
    output logic               master_ready,
    output logic               master_valid,
    output logic               read_en,
    output logic               write_en,
    output logic [BURST_W-1:0] burst,
    output logic               tx_addr,
    output logic               tx_data,
    output logic               data_next,
    output logic               tx_done
);

    localparam int CNT_W = $clog2(ADDR_W + 1);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_W - 1);

    bus_state_e         state_q, state_d;
    bus_op_e            op_q, op_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [BURST_W-1:0] beats_q, beats_d;   // beats still to send after the current one

    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               tx_addr_q, tx_addr_d;
    logic               tx_data_q, tx_data_d;
    logic               dnext_q, dnext_d;
    logic               done_q, done_d;

    logic               a_load, a_shift, a_sout;
    logic               d_load, d_shift, d_sout;
    logic [DATA_W-1:0]  d_load_val;
    logic               is_wr;

    bus_piso #(.W(ADDR_W)) u_addr_piso (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (a_load),
        .shift_i (a_shift),
        .din_i   (addr_in),
        .sout_o  (a_sout)
    );

    bus_piso #(.W(DATA_W)) u_data_piso (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (d_load),
        .shift_i (d_shift),
        .din_i   (d_load_val),
        .sout_o  (d_sout)
    );

    assign is_wr = (op_q == OP_WRITE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_READ;
            bit_q     <= '0;
            beats_q   <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            burst_q   <= '0;
            tx_addr_q <= 1'b0;
            tx_data_q <= 1'b0;
            dnext_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            bit_q     <= bit_d;
            beats_q   <= beats_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            burst_q   <= burst_d;
            tx_addr_q <= tx_addr_d;
            tx_data_q <= tx_data_d;
            dnext_q   <= dnext_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        bit_d      = bit_q;
        beats_d    = beats_q;
        ready_d    = 1'b0;
        valid_d    = 1'b0;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        burst_d    = burst_q;
        tx_addr_d  = 1'b0;
        tx_data_d  = 1'b0;
        done_d     = 1'b0;
        a_load     = 1'b0;
        a_shift    = 1'b0;
        d_load     = 1'b0;
        d_shift    = 1'b0;
        d_load_val = data_in;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (start && op_valid(read_req, write_req)) begin
                    state_d = ST_REQ;
                    op_d    = write_req ? OP_WRITE : OP_READ;
                    beats_d = burst_in;
                    burst_d = burst_in;
                    a_load  = 1'b1;
                    d_load  = 1'b1;
                    ready_d = 1'b0;
                    valid_d = 1'b1;
                    rd_d    = read_req;
                    wr_d    = write_req;
                end
            end
            ST_REQ: begin
                if (slave_ready) begin
                    state_d   = ST_ADDR;
                    bit_d     = '0;
                    tx_addr_d = a_sout;
                    a_shift   = 1'b1;
                    tx_data_d = is_wr & d_sout;
                    d_shift   = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    rd_d    = ~is_wr;
                    wr_d    = is_wr;
                end
            end
            ST_ADDR: begin
                if (bit_q == A_LAST) begin
                    if (is_wr && beats_q != '0) begin
                        // Next beat is taken straight from data_in so its bit 0
                        // goes out without a gap; the PISO keeps the rest.
                        state_d    = ST_DATA;
                        bit_d      = '0;
                        beats_d    = beats_q - BURST_W'(1);
                        d_load     = 1'b1;
                        d_load_val = data_in >> 1;
                        tx_data_d  = data_in[0];
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    bit_d     = bit_q + CNT_W'(1);
                    tx_addr_d = a_sout;
                    a_shift   = 1'b1;
                    // Write data rides along with the address for its first DATA_W bits.
                    if (is_wr && bit_q < D_LAST) begin
                        tx_data_d = d_sout;
                        d_shift   = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bit_q == D_LAST) begin
                    if (beats_q != '0) begin
                        bit_d      = '0;
                        beats_d    = beats_q - BURST_W'(1);
                        d_load     = 1'b1;
                        d_load_val = data_in >> 1;
                        tx_data_d  = data_in[0];
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    bit_d     = bit_q + CNT_W'(1);
                    tx_data_d = d_sout;
                    d_shift   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase

        // data_next is registered, so it is raised one edge early: whenever the
        // coming cycle is the last bit of a write beat that has a successor.
        dnext_d = (op_d == OP_WRITE) && (beats_d != '0) &&
                  (((state_d == ST_ADDR) && (bit_d == A_LAST)) ||
                   ((state_d == ST_DATA) && (bit_d == D_LAST)));
    end

    assign master_ready = ready_q;
    assign master_valid = valid_q;
    assign read_en      = rd_q;
    assign write_en     = wr_q;
    assign burst        = burst_q;
    assign tx_addr      = tx_addr_q;
    assign tx_data      = tx_data_q;
    assign data_next    = dnext_q;
    assign tx_done      = done_q;

endmodule

// File: tb/tb_master_out_port.sv
module tb_master_out_port;

    typedef struct packed {
        logic        ready;
        logic        valid;
        logic        rd;
        logic        wr;
        logic [12:0] burst;
        logic        ta;
        logic        td;
        logic        dn;
        logic        done;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, read_req, write_req, slave_ready;
    logic [11:0] addr_in;
    logic [7:0]  data_in;
    logic [12:0] burst_in;
    logic        master_ready, master_valid, read_en, write_en;
    logic [12:0] burst;
    logic        tx_addr, tx_data, data_next, tx_done;

    master_out_port dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .read_req     (read_req),
        .write_req    (write_req),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .burst_in     (burst_in),
        .slave_ready  (slave_ready),
        .master_ready (master_ready),
        .master_valid (master_valid),
        .read_en      (read_en),
        .write_en     (write_en),
        .burst        (burst),
        .tx_addr      (tx_addr),
        .tx_data      (tx_data),
        .data_next    (data_next),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    obs_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [12:0] last_burst = '0;

    function automatic obs_t idle_obs(input logic [12:0] b);
        obs_t o;
        o = '0;
        o.ready = 1'b1;
        o.burst = b;
        return o;
    endfunction

    // Monitor: one expected snapshot per cycle while the scoreboard holds entries.
    always @(negedge clk) begin
        obs_t got, exp;
        cyc <= cyc + 1;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            got = '{master_ready, master_valid, read_en, write_en, burst,
                    tx_addr, tx_data, data_next, tx_done};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL obs cyc=%0d got rdy/vld/rd/wr=%b%b%b%b burst=%h ta/td/dn/done=%b%b%b%b exp rdy/vld/rd/wr=%b%b%b%b burst=%h ta/td/dn/done=%b%b%b%b",
                         cyc, got.ready, got.valid, got.rd, got.wr, got.burst,
                         got.ta, got.td, got.dn, got.done,
                         exp.ready, exp.valid, exp.rd, exp.wr, exp.burst,
                         exp.ta, exp.td, exp.dn, exp.done);
            end
        end
    end

    // kind: 0 quiet, 1 start with both ops, 2 start with no op
    task automatic idle_cycles(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            sb.push_back(idle_obs(last_burst));
            start     = (kind != 0);
            read_req  = (kind == 1);
            write_req = (kind == 1);
            @(posedge clk); #1;
        end
        start = 1'b0; read_req = 1'b0; write_req = 1'b0;
    endtask

    // Called at posedge+1; that cycle is T. abort_bit >= 0 pulls reset low
    // mid-cycle while that address bit is on the line.
    task automatic do_txn(input bit is_wr, input logic [11:0] a,
                          input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input int nb, input int d, input int abort_bit);
        obs_t        tq[$];
        obs_t        e;
        logic [7:0]  w[3];
        int          ab, nxt;
        w[0] = w0; w[1] = w1; w[2] = w2;

        tq.push_back(idle_obs(last_burst));
        for (int c = 0; c <= d; c++) begin
            e = '0; e.valid = 1'b1; e.rd = !is_wr; e.wr = is_wr; e.burst = 13'(nb);
            tq.push_back(e);
        end
        for (int k = 0; k < 12; k++) begin
            e = '0; e.burst = 13'(nb);
            e.ta = a[k];
            e.td = (is_wr && k < 8) ? w[0][k] : 1'b0;
            e.dn = (k == 11) && is_wr && (nb > 0);
            tq.push_back(e);
        end
        if (is_wr) begin
            for (int b = 1; b <= nb; b++) begin
                for (int j = 0; j < 8; j++) begin
                    e = '0; e.burst = 13'(nb);
                    e.td = w[b][j];
                    e.dn = (j == 7) && (b < nb);
                    tq.push_back(e);
                end
            end
        end
        e = '0; e.burst = 13'(nb); e.done = 1'b1;
        tq.push_back(e);

        ab = (abort_bit >= 0) ? 2 + d + abort_bit : -1;
        if (ab >= 0) begin
            for (int i = 0; i < ab; i++) sb.push_back(tq[i]);
            repeat (3) sb.push_back(idle_obs('0));
        end else begin
            foreach (tq[i]) sb.push_back(tq[i]);
        end

        start = 1'b1; read_req = !is_wr; write_req = is_wr;
        addr_in = a; data_in = w[0]; burst_in = 13'(nb); slave_ready = (d == 0);
        nxt = 1;
        for (int c = 1; c < ((ab >= 0) ? ab + 1 : tq.size()); c++) begin
            @(posedge clk); #1;
            start = 1'b0; read_req = 1'b0; write_req = 1'b0;
            addr_in = 12'hFFF; burst_in = 13'h1FFF;
            slave_ready = (c >= d + 1);
            if (tq[c].dn && nxt < 3) begin
                data_in = w[nxt];
                nxt++;
            end else begin
                data_in = 8'hC3;
            end
            if (c == ab) begin
                #1 reset = 1'b0;
            end
        end
        if (ab >= 0) begin
            repeat (2) begin @(posedge clk); #1; end
            @(posedge clk); #1;
            reset = 1'b1;
            last_burst = '0;
        end else begin
            @(posedge clk); #1;
            last_burst = 13'(nb);
        end
        slave_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; read_req = 1'b0; write_req = 1'b0;
        slave_ready = 1'b0; addr_in = '0; data_in = '0; burst_in = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(idle_obs('0));
            @(posedge clk); #1;
        end
        reset = 1'b1;
        idle_cycles(2, 0);

        // single write, 0x2AA / 0x55
        do_txn(1'b1, 12'h2AA, 8'h55, 8'h00, 8'h00, 0, 0, -1);
        // read with a non-zero burst field: burst is shown but no data phase
        do_txn(1'b0, 12'hABC, 8'hFF, 8'h00, 8'h00, 5, 0, -1);
        // three-beat write burst
        do_txn(1'b1, 12'h123, 8'h11, 8'h22, 8'h33, 2, 0, -1);
        idle_cycles(1, 0);
        // slave_ready low for five cycles
        do_txn(1'b1, 12'h0F0, 8'hA7, 8'h00, 8'h00, 0, 5, -1);
        // reset while address bit 5 is on the line, then a normal request
        do_txn(1'b1, 12'h3C5, 8'h9E, 8'h00, 8'h00, 1, 0, 5);
        idle_cycles(2, 0);
        do_txn(1'b1, 12'h001, 8'h80, 8'h00, 8'h00, 0, 0, -1);
        // malformed starts are ignored
        idle_cycles(3, 1);
        idle_cycles(3, 2);
        idle_cycles(2, 0);
        do_txn(1'b0, 12'h800, 8'h00, 8'h00, 8'h00, 0, 1, -1);
        idle_cycles(2, 0);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
